// File: rtl/imem_server.sv
// Instruction-memory responder with a byte-stream program loader.
// The loader fills the array while the core is held off, then releases core_en.
module imem_server #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] FILL_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_data,
  output logic        core_en,
  input  logic        load_start,
  input  logic [15:0] load_len,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic              core_en_q, core_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       fetch_data_q, fetch_data_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem [DEPTH];

  logic              len_zero;
  logic              len_over;
  logic              addr_in_range;

  assign len_zero      = (load_len == 16'd0);
  assign len_over      = (32'(load_len) > DEPTH);
  assign addr_in_range = (32'(fetch_addr) < DEPTH);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    len_d     = len_q;
    hi_d      = hi_q;
    err_d     = err_q;
    done_d    = 1'b0;
    core_en_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wptr_q[ADDR_W-1:0];
    mem_wdata = {hi_q, load_byte};

    case (state_q)
      // RUN shares the IDLE length rules; a start there also drops core_en.
      IDLE, RUN: begin
        core_en_d = (state_q == RUN) && !load_start;
        if (load_start) begin
          if (len_zero) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (len_over) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD_HI;
            len_d   = load_len[ADDR_W:0];
            wptr_d  = '0;
            err_d   = 1'b0;
          end
        end
      end
      LOAD_HI: begin
        if (load_valid) begin
          hi_d    = load_byte;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (load_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_d == len_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    fetch_data_d = (core_en_q && addr_in_range) ?
                   mem[fetch_addr[ADDR_W-1:0]] : FILL_WORD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      len_q        <= '0;
      hi_q         <= '0;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fetch_data_q <= FILL_WORD;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      core_en_q    <= core_en_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fetch_data_q <= fetch_data_d;
    end
  end

  // The array is deliberately not reset so a partial load survives rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign load_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign core_en    = core_en_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign fetch_data = fetch_data_q;

endmodule

// File: tb/tb_imem_server.sv
// Self-checking bench for imem_server: table-driven fetch vectors fed
// through an expected-value queue, plus hand-written loader sequences.
module tb_imem_server;

  logic        clk;
  logic        rst_n;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_data;
  logic        core_en;
  logic        load_start;
  logic [15:0] load_len;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_done;
  logic        load_err;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } fetchVec_t;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [15:0] expQ[$];
  logic [15:0] progWords[$];
  fetchVec_t   vecs[$];

  imem_server #(.ADDR_W(10), .FILL_WORD(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .core_en    (core_en),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference content written by the full-depth load.
  function automatic logic [15:0] fullWord(input int i);
    return 16'(i) ^ 16'hC3A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives each fetch vector and checks it one cycle later via the queue.
  task automatic applyStimulus();
    logic [15:0] exp;
    for (int i = 0; i < vecs.size(); i++) begin
      fetch_addr = vecs[i].addr;
      expQ.push_back(vecs[i].exp);
      tick();
      exp = expQ.pop_front();
      checkOutput("fetch_data", fetch_data, exp);
    end
    fetch_addr = 16'h0000;
  endtask

  task automatic addVec(input logic [15:0] a, input logic [15:0] e);
    fetchVec_t v;
    v.addr = a;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Loads progWords; with gaps, load_valid idles a cycle before each byte
  // while load_byte carries junk that must never reach memory.
  task automatic loadProgram(input logic [15:0] len, input bit gaps);
    logic [7:0] b;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("core_en_after_start", core_en, 1'b0);
    checkOutput("load_err_cleared", load_err, 1'b0);
    for (int w = 0; w < progWords.size(); w++) begin
      for (int h = 0; h < 2; h++) begin
        b = (h == 0) ? progWords[w][15:8] : progWords[w][7:0];
        if (gaps) begin
          load_valid = 1'b0;
          load_byte  = 8'hEE;
          tick();
          checkOutput("ready_in_gap", load_ready, 1'b1);
        end
        load_valid = 1'b1;
        load_byte  = b;
        checkOutput("load_ready", load_ready, 1'b1);
        checkOutput("no_early_done", load_done, 1'b0);
        tick();
      end
    end
    load_valid = 1'b0;
    checkOutput("load_done_pulse", load_done, 1'b1);
    checkOutput("core_en_before_rise", core_en, 1'b0);
    checkOutput("ready_after_load", load_ready, 1'b0);
    tick();
    checkOutput("load_done_clear", load_done, 1'b0);
    checkOutput("core_en_rise", core_en, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_addr = 16'h0000;
    load_start = 1'b0;
    load_len   = 16'h0000;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    #3;
    checkOutput("rst_core_en", core_en, 1'b0);
    checkOutput("rst_fetch_data", fetch_data, 16'h0000);
    checkOutput("rst_load_ready", load_ready, 1'b0);
    checkOutput("rst_load_done", load_done, 1'b0);
    checkOutput("rst_load_err", load_err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] overflow length rejected");
    load_len   = 16'd1025;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("ovf_err", load_err, 1'b1);
    checkOutput("ovf_core_en", core_en, 1'b0);
    checkOutput("ovf_ready", load_ready, 1'b0);
    checkOutput("ovf_done", load_done, 1'b0);
    tick();
    tick();
    checkOutput("ovf_err_sticky", load_err, 1'b1);
    checkOutput("ovf_ready_idle", load_ready, 1'b0);

    $display("[TB] full-depth load");
    progWords.delete();
    for (int i = 0; i < 1024; i++) progWords.push_back(fullWord(i));
    loadProgram(16'd1024, 1'b0);
    vecs.delete();
    addVec(16'h0000, fullWord(0));
    addVec(16'h0200, fullWord(16'h200));
    addVec(16'h03FF, fullWord(16'h3FF));
    addVec(16'h0400, 16'h0000);
    addVec(16'hFFFF, 16'h0000);
    addVec(16'h0401, 16'h0000);
    addVec(16'h03FF, fullWord(16'h3FF));
    addVec(16'h8003, 16'h0000);
    applyStimulus();

    $display("[TB] three-word load");
    load_len   = 16'd3;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("reload_core_en_drop", core_en, 1'b0);
    progWords.delete();
    progWords.push_back(16'h1234);
    progWords.push_back(16'h5678);
    progWords.push_back(16'h9ABC);
    for (int w = 0; w < 3; w++) begin
      for (int h = 0; h < 2; h++) begin
        load_valid = 1'b1;
        load_byte  = (h == 0) ? progWords[w][15:8] : progWords[w][7:0];
        checkOutput("t1_ready", load_ready, 1'b1);
        tick();
      end
    end
    load_valid = 1'b0;
    checkOutput("t1_done", load_done, 1'b1);
    checkOutput("t1_core_en_low", core_en, 1'b0);
    tick();
    checkOutput("t1_done_clear", load_done, 1'b0);
    checkOutput("t1_core_en_high", core_en, 1'b1);
    vecs.delete();
    addVec(16'h0000, 16'h1234);
    addVec(16'h0001, 16'h5678);
    addVec(16'h0002, 16'h9ABC);
    addVec(16'h0003, fullWord(3));
    addVec(16'h0400, 16'h0000);
    applyStimulus();

    $display("[TB] reload from RUN with ignored mid-load start");
    checkOutput("t5_core_en_run", core_en, 1'b1);
    load_len   = 16'd1;
    load_start = 1'b1;
    tick();
    checkOutput("t5_core_en_fall", core_en, 1'b0);
    checkOutput("t5_ready", load_ready, 1'b1);
    load_len   = 16'd5;
    load_valid = 1'b1;
    load_byte  = 8'hAB;
    tick();
    load_start = 1'b0;
    load_byte  = 8'hCD;
    checkOutput("t5_ready_lo", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    checkOutput("t5_done", load_done, 1'b1);
    checkOutput("t5_err_unchanged", load_err, 1'b0);
    tick();
    checkOutput("t5_core_en_rise", core_en, 1'b1);
    vecs.delete();
    addVec(16'h0000, 16'hABCD);
    addVec(16'h0001, 16'h5678);
    applyStimulus();

    $display("[TB] gapped load restores program");
    progWords.delete();
    progWords.push_back(16'h1234);
    progWords.push_back(16'h5678);
    progWords.push_back(16'h9ABC);
    loadProgram(16'd3, 1'b1);
    vecs.delete();
    addVec(16'h0000, 16'h1234);
    addVec(16'h0001, 16'h5678);
    addVec(16'h0002, 16'h9ABC);
    applyStimulus();

    $display("[TB] reset mid-load");
    load_len   = 16'd2;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_byte  = 8'h55;
    tick();
    load_byte  = 8'h66;
    tick();
    load_byte  = 8'h77;
    tick();
    load_valid = 1'b0;
    checkOutput("t6_ready_before_rst", load_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready", load_ready, 1'b0);
    checkOutput("t6_rst_core_en", core_en, 1'b0);
    checkOutput("t6_rst_done", load_done, 1'b0);
    checkOutput("t6_rst_fetch", fetch_data, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("t6_core_en_held", core_en, 1'b0);
    vecs.delete();
    addVec(16'h0000, 16'h0000);
    applyStimulus();
    load_len   = 16'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("t6_zero_done", load_done, 1'b1);
    checkOutput("t6_zero_core_en_low", core_en, 1'b0);
    tick();
    checkOutput("t6_zero_core_en", core_en, 1'b1);
    vecs.delete();
    addVec(16'h0000, 16'h5566);
    addVec(16'h0001, 16'h5678);
    addVec(16'h0002, 16'h9ABC);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
